// File: rtl/rbm_visible_recon_if.sv
// rbm_visible_recon_if: start/busy/done handshake plus operand and result buses of the visible reconstruction core
interface rbm_visible_recon_if #(
  parameter int J_DIM = 256
);
  logic start;
  logic busy;
  logic done;
  logic signed [7:0] h_mem [J_DIM];
  logic signed [15:0] w_row [J_DIM];
  logic signed [31:0] a_i;
  logic [15:0] p_i;
  modport master (output start, h_mem, w_row, a_i, input busy, done, p_i);
  modport slave (input start, h_mem, w_row, a_i, output busy, done, p_i);
endinterface

// File: rtl/rbm_visible_recon.sv
// rbm_visible_recon: hidden-to-visible RBM pass, p_i = sigmoid(a_i + sum_j h_j*w_ij) using one MAC per cycle and a sigmoid ROM
module rbm_visible_recon #(
  parameter int J_DIM = 256,
  parameter int ACC_W = 40,
  parameter int FRAC_SHIFT = 7
) (
  input logic clk,
  input logic rst,
  rbm_visible_recon_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC = 2'd1;
  localparam logic [1:0] S_SAT = 2'd2;
  localparam logic [1:0] S_LUT = 2'd3;
  localparam int JW = (J_DIM > 1) ? $clog2(J_DIM) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(J_DIM - 1);
  // acc bounds equivalent to saturating (acc >>> FRAC_SHIFT) to 16 bits
  localparam logic signed [ACC_W-1:0] ACC_HI = ACC_W'(64'sd32768 <<< FRAC_SHIFT);
  localparam logic signed [ACC_W-1:0] ACC_LO = -ACC_HI;
  logic [1:0] r_state;
  logic [JW-1:0] r_j;
  logic signed [ACC_W-1:0] r_acc;
  logic [9:0] r_idx;
  logic r_busy;
  logic r_done;
  logic [15:0] r_p;
  logic signed [23:0] w_prod;
  logic [15:0] w_lut [1024];
  function automatic logic [15:0] sig_q16(input int k);
    real s;
    s = 65535.0 / (1.0 + $exp(-real'(k - 512) / 16.0));
    return (s >= 65534.5) ? 16'hFFFF : 16'($rtoi(s + 0.5));
  endfunction
  // ROM contents are fixed at elaboration: entry k = round(65535*sigmoid((k-512)/16))
  for (genvar k = 0; k < 1024; k++) begin : g_lut
    localparam logic [15:0] V = sig_q16(k);
    assign w_lut[k] = V;
  end
  assign w_prod = 24'(bus.h_mem[r_j]) * 24'(bus.w_row[r_j]);
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.p_i = r_p;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_j <= '0;
      r_acc <= '0;
      r_idx <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_p <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc <= ACC_W'(bus.a_i);
            r_j <= '0;
            r_busy <= 1'b1;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          r_j <= r_j + JW'(1);
          r_state <= (r_j == J_LAST) ? S_SAT : S_ACC;
        end
        S_SAT: begin
          // in-range index is x[15:6] + 512, i.e. the sign bit of x[15:6] inverted
          r_idx <= (r_acc >= ACC_HI) ? 10'h3FF :
                   (r_acc < ACC_LO) ? 10'h000 :
                   {~r_acc[FRAC_SHIFT+15], r_acc[FRAC_SHIFT+14:FRAC_SHIFT+6]};
          r_state <= S_LUT;
        end
        default: begin
          r_p <= w_lut[r_idx];
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
